// File: rtl/hpm_sampler.sv
// hpm_sampler: scans mhpmcounter3.. over a CSR port, either periodically or on
// a snapshot request, and queues {index, value, last} samples in a FIFO.
// Optional: define HPM_SAMPLER_CLEAR_EN to zero each counter right after it is read.
module hpm_sampler #(
    parameter int NUM_CTR    = 6,
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic [15:0]     period_i,
    input  logic            snapshot_i,
    output logic [11:0]     addr_o,
    output logic            we_o,
    output logic [XLEN-1:0] wdata_o,
    input  logic [XLEN-1:0] rdata_i,
    output logic            sample_valid_o,
    input  logic            sample_ready_i,
    output logic [2:0]      sample_idx_o,
    output logic [63:0]     sample_data_o,
    output logic            sample_last_o,
    output logic [7:0]      drop_cnt_o,
    output logic            busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam bit HAS_HI = (XLEN == 32);
`ifdef HPM_SAMPLER_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif
    // Highest fill level at which a whole scan still fits.
    localparam logic [AW:0] MAX_FILL = (AW+1)'(FIFO_DEPTH - NUM_CTR);

    typedef enum logic [2:0] {IDLE, WAIT, RD_LO, RD_HI, CLR, NEXT} state_e;

    state_e        state_q;
    logic [15:0]   timer_q;
    logic [2:0]    idx_q;
    logic          clr_hi_q;
    logic [63:0]   sample_q;
    logic [11:0]   addr_q;
    logic          we_q;
    logic          busy_q;
    logic [7:0]    drop_q;

    logic [2:0]    mem_idx  [FIFO_DEPTH];
    logic [63:0]   mem_data [FIFO_DEPTH];
    logic          mem_last [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;

    logic [15:0] per_ld;
    logic        room, tick, trig, last_idx, push, pop;

    assign per_ld   = (period_i == 16'd0) ? 16'd1 : period_i;
    assign room     = (cnt_q <= MAX_FILL);
    assign tick     = (state_q != IDLE) && (timer_q == 16'd1);
    assign trig     = ((state_q == IDLE) && snapshot_i) ||
                      ((state_q == WAIT) && (snapshot_i || tick));
    assign last_idx = (idx_q == 3'(NUM_CTR - 1));
    assign push     = (state_q == NEXT);
    assign pop      = sample_valid_o && sample_ready_i;

    function automatic logic [11:0] lo_addr(input logic [2:0] i);
        return 12'hB03 + {9'd0, i};
    endfunction

    function automatic logic [11:0] hi_addr(input logic [2:0] i);
        return 12'hB83 + {9'd0, i};
    endfunction

    // Scan FSM, period timer, drop counter and registered CSR access outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            timer_q  <= 16'd0;
            idx_q    <= 3'd0;
            clr_hi_q <= 1'b0;
            sample_q <= 64'd0;
            addr_q   <= 12'h000;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            addr_q <= 12'h000;
            we_q   <= 1'b0;
            // Timer keeps running through a scan so scan starts stay period-aligned.
            if (state_q != IDLE && timer_q != 16'd0)
                timer_q <= tick ? per_ld : timer_q - 16'd1;
            // A trigger with no FIFO room, or a period tick mid-scan, is a skipped scan.
            if (((trig && !room) || (busy_q && tick)) && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;
            case (state_q)
                IDLE: begin
                    if (enable_i) timer_q <= per_ld;
                    if (trig && room) begin
                        state_q <= RD_LO;
                        idx_q   <= 3'd0;
                        addr_q  <= lo_addr(3'd0);
                        busy_q  <= 1'b1;
                    end else if (!trig && enable_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (trig && room) begin
                        state_q <= RD_LO;
                        idx_q   <= 3'd0;
                        addr_q  <= lo_addr(3'd0);
                        busy_q  <= 1'b1;
                    end else if (!trig && !enable_i) begin
                        state_q <= IDLE;
                        timer_q <= 16'd0;
                    end
                end
                RD_LO: begin
                    sample_q[XLEN-1:0] <= rdata_i;
                    if (HAS_HI) begin
                        state_q <= RD_HI;
                        addr_q  <= hi_addr(idx_q);
                    end else if (CLR_EN) begin
                        state_q  <= CLR;
                        addr_q   <= lo_addr(idx_q);
                        we_q     <= 1'b1;
                        clr_hi_q <= 1'b0;
                    end else begin
                        state_q <= NEXT;
                    end
                end
                RD_HI: begin
                    sample_q[63:32] <= rdata_i[31:0];
                    if (CLR_EN) begin
                        state_q  <= CLR;
                        addr_q   <= lo_addr(idx_q);
                        we_q     <= 1'b1;
                        clr_hi_q <= 1'b0;
                    end else begin
                        state_q <= NEXT;
                    end
                end
                CLR: begin
                    if (HAS_HI && !clr_hi_q) begin
                        clr_hi_q <= 1'b1;
                        addr_q   <= hi_addr(idx_q);
                        we_q     <= 1'b1;
                    end else begin
                        clr_hi_q <= 1'b0;
                        state_q  <= NEXT;
                    end
                end
                NEXT: begin
                    if (last_idx) begin
                        idx_q   <= 3'd0;
                        busy_q  <= 1'b0;
                        state_q <= enable_i ? WAIT : IDLE;
                        if (!enable_i) timer_q <= 16'd0;
                        else if (timer_q == 16'd0) timer_q <= per_ld;
                    end else begin
                        idx_q   <= idx_q + 3'd1;
                        state_q <= RD_LO;
                        addr_q  <= lo_addr(idx_q + 3'd1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sample FIFO; the head is read straight out of registered storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_idx[k]  <= 3'd0;
                mem_data[k] <= 64'd0;
                mem_last[k] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_idx[wr_ptr_q]  <= idx_q;
                mem_data[wr_ptr_q] <= sample_q;
                mem_last[wr_ptr_q] <= last_idx;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign sample_valid_o = (cnt_q != '0);
    assign sample_idx_o   = mem_idx[rd_ptr_q];
    assign sample_data_o  = mem_data[rd_ptr_q];
    assign sample_last_o  = mem_last[rd_ptr_q];
    assign addr_o         = addr_q;
    assign we_o           = we_q;
    assign wdata_o        = '0;
    assign drop_cnt_o     = drop_q;
    assign busy_o         = busy_q;
endmodule

// File: tb/tb_hpm_sampler.sv
// Scoreboard bench for hpm_sampler: a 64-bit instance for the main scenarios
// and a 32-bit instance for the split lo/hi read path.
module tb_hpm_sampler;
    typedef struct packed {
        logic [2:0]  idx;
        logic [63:0] data;
        logic        last;
    } smp_t;

    logic clk, rst_n;
    logic en, snap, sr;
    logic [15:0] per;
    logic [11:0] addr;
    logic we, sv, slast, busy;
    logic [63:0] wdata, rdata, sdata;
    logic [2:0] sidx;
    logic [7:0] drop;

    logic en32, snap32, sr32;
    logic [11:0] addr32;
    logic we32, sv32, slast32, busy32;
    logic [31:0] wdata32, rdata32;
    logic [63:0] sdata32;
    logic [2:0] sidx32;
    logic [7:0] drop32;

    int n_chk = 0, n_fail = 0, cyc = 0;
    smp_t exp_q[$], exp32_q[$];
    logic [12:0] acc_q[$], acc32_q[$];
    int starts[$];

    hpm_sampler #(.NUM_CTR(6), .XLEN(64), .FIFO_DEPTH(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .period_i(per), .snapshot_i(snap),
        .addr_o(addr), .we_o(we), .wdata_o(wdata), .rdata_i(rdata),
        .sample_valid_o(sv), .sample_ready_i(sr), .sample_idx_o(sidx),
        .sample_data_o(sdata), .sample_last_o(slast), .drop_cnt_o(drop), .busy_o(busy));

    hpm_sampler #(.NUM_CTR(6), .XLEN(32), .FIFO_DEPTH(8)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en32), .period_i(per), .snapshot_i(snap32),
        .addr_o(addr32), .we_o(we32), .wdata_o(wdata32), .rdata_i(rdata32),
        .sample_valid_o(sv32), .sample_ready_i(sr32), .sample_idx_o(sidx32),
        .sample_data_o(sdata32), .sample_last_o(slast32), .drop_cnt_o(drop32), .busy_o(busy32));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter block models: counter i reads 0x100+i; 32-bit counter 0 is 0x1_0000_0002.
    always_comb begin
        rdata = 64'd0;
        if (addr >= 12'hB03 && addr <= 12'hB0A) rdata = 64'h100 + 64'(addr - 12'hB03);
    end
    always_comb begin
        rdata32 = 32'd0;
        if (addr32 == 12'hB03) rdata32 = 32'h2;
        else if (addr32 > 12'hB03 && addr32 <= 12'hB0A) rdata32 = 32'h200 + 32'(addr32 - 12'hB03);
        else if (addr32 == 12'hB83) rdata32 = 32'h1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors: pop expected samples/accesses as the DUTs present them.
    always @(negedge clk) begin
        if (sv && sr) begin
            if (exp_q.size() == 0) chk("sample64_unexpected", {sidx, sdata, slast}, 68'd0 - 1);
            else chk("sample64", {61'd0, sidx, sdata, slast} >> 0, {61'd0, exp_q.pop_front()} >> 0);
        end
        if (addr != 12'h000 || we) begin
            if (addr == 12'hB03 && !we) starts.push_back(cyc);
            if (acc_q.size() == 0) chk("access64_unexpected", {51'd0, we, addr}, 64'd0);
            else chk("access64", {51'd0, we, addr}, {51'd0, acc_q.pop_front()});
        end
        if (sv32 && sr32) begin
            if (exp32_q.size() == 0) chk("sample32_unexpected", {61'd0, sidx32}, 64'hFF);
            else chk("sample32", {61'd0, sidx32, sdata32, slast32} >> 0, {61'd0, exp32_q.pop_front()} >> 0);
        end
        if (addr32 != 12'h000 || we32) begin
            if (acc32_q.size() == 0) chk("access32_unexpected", {51'd0, we32, addr32}, 64'd0);
            else chk("access32", {51'd0, we32, addr32}, {51'd0, acc32_q.pop_front()});
        end
    end

    // Expected 64-bit scan: ns samples, na reads (clears only for completed entries).
    task automatic q64(input int ns, input int na);
        smp_t s;
        for (int i = 0; i < ns; i++) begin
            s.idx = 3'(i); s.data = 64'h100 + 64'(i); s.last = (i == 5);
            exp_q.push_back(s);
        end
        for (int i = 0; i < na; i++) begin
            acc_q.push_back({1'b0, 12'hB03 + 12'(i)});
`ifdef HPM_SAMPLER_CLEAR_EN
            if (i < ns) acc_q.push_back({1'b1, 12'hB03 + 12'(i)});
`endif
        end
    endtask

    task automatic q32();
        smp_t s;
        for (int i = 0; i < 6; i++) begin
            s.idx = 3'(i); s.data = (i == 0) ? 64'h1_0000_0002 : 64'h200 + 64'(i); s.last = (i == 5);
            exp32_q.push_back(s);
            acc32_q.push_back({1'b0, 12'hB03 + 12'(i)});
            acc32_q.push_back({1'b0, 12'hB83 + 12'(i)});
`ifdef HPM_SAMPLER_CLEAR_EN
            acc32_q.push_back({1'b1, 12'hB03 + 12'(i)});
            acc32_q.push_back({1'b1, 12'hB83 + 12'(i)});
`endif
        end
    endtask

    task automatic wait_drain(input string nm, input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            if (exp_q.size() == 0 && acc_q.size() == 0 && exp32_q.size() == 0 && acc32_q.size() == 0) break;
            @(negedge clk);
        end
        chk({nm, "_drain_timeout"}, 64'(k >= bound), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_valid"}, 64'(sv), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_drop"}, 64'(drop), 64'd0);
        chk({nm, "_addr"}, 64'(addr), 64'd0);
        chk({nm, "_we"}, 64'(we), 64'd0);
        chk({nm, "_wdata"}, wdata, 64'd0);
        chk({nm, "_idx"}, 64'(sidx), 64'd0);
        chk({nm, "_data"}, sdata, 64'd0);
        chk({nm, "_last"}, 64'(slast), 64'd0);
    endtask

    task automatic pulse(input bit use32);
        @(posedge clk); #1;
        if (use32) snap32 = 1'b1; else snap = 1'b1;
        @(posedge clk); #1;
        snap = 1'b0; snap32 = 1'b0;
    endtask

    initial begin
        int k;
        en = 0; snap = 0; sr = 1; per = 16'd0;
        en32 = 0; snap32 = 0; sr32 = 1;
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk); #1 rst_n = 1;

        // Snapshot scan, 64-bit.
        q64(6, 6);
        pulse(0);
        wait_drain("snap64", 100);
        chk("snap64_busy_after", 64'(busy), 64'd0);

        // Snapshot scan, 32-bit split reads.
        q32();
        pulse(1);
        wait_drain("snap32", 150);

        // Periodic scans, period 20.
        starts.delete();
        q64(6, 6); q64(6, 6); q64(6, 6);
        per = 16'd20; en = 1;
        for (k = 0; k < 300 && starts.size() < 3; k++) @(negedge clk);
        en = 0;
        chk("periodic_timeout", 64'(starts.size() < 3), 64'd0);
        wait_drain("periodic", 100);
        if (starts.size() >= 3) begin
            chk("period_gap1", 64'(starts[1] - starts[0]), 64'd20);
            chk("period_gap2", 64'(starts[2] - starts[1]), 64'd20);
        end
        chk("periodic_drop", 64'(drop), 64'd0);

        // Back-pressure: second scan must be skipped.
        sr = 0;
        q64(6, 6);
        pulse(0);
        repeat (25) @(negedge clk);
        chk("hold_valid", 64'(sv), 64'd1);
        chk("hold_idx", 64'(sidx), 64'd0);
        chk("hold_data", sdata, 64'h100);
        pulse(0);
        repeat (5) @(negedge clk);
        chk("drop_cnt", 64'(drop), 64'd1);
        chk("drop_busy", 64'(busy), 64'd0);
        chk("hold_data2", sdata, 64'h100);
        sr = 1;
        wait_drain("drop", 60);

        // Reset during RD_LO of index 3.
        q64(3, 4);
        pulse(0);
        for (k = 0; k < 60 && !(addr == 12'hB06 && !we); k++) @(negedge clk);
        chk("midreset_reach", 64'(k >= 60), 64'd0);
        #1 rst_n = 0;
        #1 chk_reset("midreset");
        @(posedge clk); #1 rst_n = 1;
        repeat (30) @(negedge clk);
        chk("post_reset_valid", 64'(sv), 64'd0);
        chk("post_reset_busy", 64'(busy), 64'd0);

        chk("end_exp64_left", 64'(exp_q.size()), 64'd0);
        chk("end_acc64_left", 64'(acc_q.size()), 64'd0);
        chk("end_exp32_left", 64'(exp32_q.size()), 64'd0);
        chk("end_acc32_left", 64'(acc32_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/hpm_sampler.md
HPM_SAMPLER -- requirements
Module: hpm_sampler

Interface
REQ-001 SHALL have parameter NUM_CTR, default 6, number of HPM counters scanned (1..8).
REQ-002 SHALL have parameter XLEN, default 64, CSR data width (32 or 64).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, sample FIFO entries (power of 2, >= NUM_CTR).
REQ-004 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable_i  input  1  periodic sampling enable.
REQ-007 SHALL have port period_i  input  16  cycles between scan starts.
REQ-008 SHALL have port snapshot_i  input  1  single-cycle request for an immediate scan.
REQ-009 SHALL have port addr_o  output  12  CSR address to the counter block.
REQ-010 SHALL have port we_o  output  1  CSR write enable.
REQ-011 SHALL have port wdata_o  output  XLEN  CSR write data.
REQ-012 SHALL have port rdata_i  input  XLEN  CSR read data, combinational in the same cycle as addr_o.
REQ-013 SHALL have port sample_valid_o  output  1  FIFO head valid.
REQ-014 SHALL have port sample_ready_i  input  1  consumer accepts head.
REQ-015 SHALL have port sample_idx_o  output  3  counter index (0 = mhpmcounter3).
REQ-016 SHALL have port sample_data_o  output  64  counter value.
REQ-017 SHALL have port sample_last_o  output  1  marks the last counter of a scan.
REQ-018 SHALL have port drop_cnt_o  output  8  skipped scans, saturating.
REQ-019 SHALL have port busy_o  output  1  scan in progress.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT, RD_LO, RD_HI, CLR, NEXT.
REQ-021 SHALL go IDLE->WAIT on enable_i=1 and load the timer with max(period_i,1).
REQ-022 SHALL decrement the timer in WAIT each cycle; on reaching 1, reload it and raise a scan trigger.
REQ-023 SHALL raise a scan trigger when snapshot_i=1 in IDLE or WAIT; snapshot_i SHALL be ignored while busy_o=1.
REQ-024 SHALL start a scan on trigger only if FIFO free entries >= NUM_CTR; otherwise SHALL skip it, increment drop_cnt_o (saturating at 255) and stay in the current state.
REQ-025 SHALL in RD_LO drive addr_o=0xB03+i, we_o=0 and capture rdata_i into the low XLEN bits of the sample.
REQ-026 SHALL for XLEN=32 follow RD_LO with RD_HI at addr_o=0xB83+i, capturing bits 63:32; for XLEN=64 SHALL skip RD_HI.
REQ-027 SHALL in NEXT push {i, value, i==NUM_CTR-1} into the FIFO, then go to RD_LO with i+1, or end the scan after the last index.
REQ-028 SHALL at scan end return to WAIT if enable_i=1, else to IDLE; deasserting enable_i mid-scan SHALL NOT abort the scan.
REQ-029 SHALL drive addr_o=0, we_o=0 and wdata_o=0 in every state that issues no access.
REQ-030 SHALL assert busy_o in RD_LO, RD_HI, CLR and NEXT.
REQ-031 SHALL pop the FIFO when sample_valid_o && sample_ready_i; simultaneous push and pop SHALL both occur.
REQ-032 SHALL present FIFO output registered: the first sample appears on sample_valid_o one cycle after its NEXT cycle.
REQ-033 SHALL keep sample_* outputs stable while sample_valid_o=1 and sample_ready_i=0.

Reset
REQ-034 SHALL on rst_ni=0 set FSM=IDLE, timer=0, i=0, FIFO empty, sample_valid_o=0, sample_idx_o=0, sample_data_o=0, sample_last_o=0, drop_cnt_o=0, busy_o=0, addr_o=0, we_o=0 and wdata_o=0.
REQ-035 SHALL on reset mid-scan discard the partial scan; no partial sample is ever pushed.

Configuration
REQ-036 SHALL, with HPM_SAMPLER_CLEAR_EN defined, insert CLR after RD_LO (after RD_HI for XLEN=32) writing zero: addr_o=0xB03+i, we_o=1, wdata_o=0; for XLEN=32 a second CLR cycle SHALL write zero to 0xB83+i.
REQ-037 SHALL, without HPM_SAMPLER_CLEAR_EN, never assert we_o and omit the CLR state.

Verification
REQ-038 SHALL verify: XLEN=64, snapshot_i pulse, rdata_i=0x100+index -> 6 samples idx 0..5, data 0x100..0x105, last only on idx 5, addr_o 0xB03..0xB08.
REQ-039 SHALL verify: enable_i=1, period_i=20, sample_ready_i=1 -> consecutive scans start exactly 20 cycles apart.
REQ-040 SHALL verify: sample_ready_i=0 with FIFO_DEPTH=8, two triggers -> first scan fills 6 entries, second is skipped, drop_cnt_o=1.
REQ-041 SHALL verify: XLEN=32, counter value 0x1_0000_0002 -> RD_LO at 0xB03 then RD_HI at 0xB83, sample_data_o=0x1_0000_0002.
REQ-042 SHALL verify: HPM_SAMPLER_CLEAR_EN defined -> each read is followed by we_o=1, wdata_o=0 at the same address; undefined -> we_o stays 0.
REQ-043 SHALL verify: rst_ni asserted during RD_LO of index 3 -> all outputs return to reset values and no sample is emitted after release.
